// File: rtl/dsp_addsub_seq_if.sv
// Request/response bus of the multi-limb add/sub unit.
//   in_valid/in_ready  : request handshake (op_sub, a, b sampled on accept)
//   out_valid/out_ready: result handshake (result, carry_out, overflow, zero)
//   master drives requests and consumes results; slave is the arithmetic unit.
interface dsp_addsub_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/dsp_addsub_seq.sv
// Sequential WIDTH-bit add/subtract, one 32-bit limb per clock, LSB limb first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dsp_addsub_seq_if.slave (request in, registered result/flags out)
// The per-limb adder is the 32-bit adder path of an SB_MAC16 (registers bypassed,
// carry-in from r_carry, carry-out to r_carry); B inversion for subtract is fabric.
module dsp_addsub_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  dsp_addsub_seq_if.slave  bus
);
  localparam int unsigned LIMB_W = 32;
  localparam int unsigned NLIMBS = WIDTH / LIMB_W;
  localparam int unsigned IDX_W  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

  logic [1:0]       r_state,     w_state;
  logic             r_in_ready,  w_in_ready;
  logic [WIDTH-1:0] r_a,         w_a;
  logic [WIDTH-1:0] r_b,         w_b;
  logic             r_op_sub,    w_op_sub;
  logic [IDX_W-1:0] r_idx,       w_idx;
  logic             r_carry,     w_carry;
  logic             r_zero_acc,  w_zero_acc;
  logic [WIDTH-1:0] r_result,    w_result;
  logic             r_out_valid, w_out_valid;
  logic             r_carry_out, w_carry_out;
  logic             r_overflow,  w_overflow;
  logic             r_zero,      w_zero;

  logic [LIMB_W-1:0] w_b_eff;
  logic [LIMB_W:0]   w_limb_sum;
  logic              w_limb_zero;

  // Limb adder; operands are shifted down so the current limb is always bits [31:0].
  always_comb begin
    w_b_eff     = r_op_sub ? ~r_b[LIMB_W-1:0] : r_b[LIMB_W-1:0];
    w_limb_sum  = {1'b0, r_a[LIMB_W-1:0]} + {1'b0, w_b_eff} + (LIMB_W+1)'(r_carry);
    w_limb_zero = (w_limb_sum[LIMB_W-1:0] == '0);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_in_ready  = r_in_ready;
    w_a         = r_a;
    w_b         = r_b;
    w_op_sub    = r_op_sub;
    w_idx       = r_idx;
    w_carry     = r_carry;
    w_zero_acc  = r_zero_acc;
    w_result    = r_result;
    w_out_valid = r_out_valid;
    w_carry_out = r_carry_out;
    w_overflow  = r_overflow;
    w_zero      = r_zero;

    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && r_in_ready) begin
          w_a        = bus.a;
          w_b        = bus.b;
          w_op_sub   = bus.op_sub;
          w_idx      = '0;
          w_carry    = bus.op_sub;  // +1 of the two's-complement negate
          w_zero_acc = 1'b1;
          w_in_ready = 1'b0;
          w_state    = CALC;
        end
      end
      CALC: begin
        w_a        = r_a >> LIMB_W;
        w_b        = r_b >> LIMB_W;
        // New limb enters at the top; after NLIMBS steps limb i sits at position i.
        w_result   = (r_result >> LIMB_W) |
                     (WIDTH'(w_limb_sum[LIMB_W-1:0]) << (WIDTH - LIMB_W));
        w_carry    = w_limb_sum[LIMB_W];
        w_zero_acc = r_zero_acc & w_limb_zero;
        w_idx      = r_idx + IDX_W'(1);
        if (r_idx == LAST_IDX) begin
          w_idx       = '0;
          w_state     = DONE;
          w_out_valid = 1'b1;
          w_carry_out = w_limb_sum[LIMB_W];
          // Same-sign operands producing a different-sign result.
          w_overflow  = (r_a[LIMB_W-1] == w_b_eff[LIMB_W-1]) &&
                        (w_limb_sum[LIMB_W-1] != r_a[LIMB_W-1]);
          w_zero      = r_zero_acc & w_limb_zero;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid = 1'b0;
          w_in_ready  = 1'b1;
          w_state     = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op_sub    <= 1'b0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_zero_acc  <= 1'b1;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_in_ready  <= w_in_ready;
      r_a         <= w_a;
      r_b         <= w_b;
      r_op_sub    <= w_op_sub;
      r_idx       <= w_idx;
      r_carry     <= w_carry;
      r_zero_acc  <= w_zero_acc;
      r_result    <= w_result;
      r_out_valid <= w_out_valid;
      r_carry_out <= w_carry_out;
      r_overflow  <= w_overflow;
      r_zero      <= w_zero;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_dsp_addsub_seq.sv
// Self-checking bench: a 64-bit and a 128-bit instance, directed corner cases
// plus randomized operations checked against a plain-arithmetic reference model.
module tb_dsp_addsub_seq;
  logic clk;
  logic rst_n;

  logic         sel;        // 0 = 64-bit instance, 1 = 128-bit instance
  logic         in_valid;
  logic         op_sub;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_ready;

  int n_tests;
  int n_fail;

  dsp_addsub_seq_if #(.WIDTH(64))  if64 ();
  dsp_addsub_seq_if #(.WIDTH(128)) if128 ();

  assign if64.in_valid   = in_valid & ~sel;
  assign if64.op_sub     = op_sub;
  assign if64.a          = a[63:0];
  assign if64.b          = b[63:0];
  assign if64.out_ready  = out_ready;
  assign if128.in_valid  = in_valid & sel;
  assign if128.op_sub    = op_sub;
  assign if128.a         = a;
  assign if128.b         = b;
  assign if128.out_ready = out_ready;

  dsp_addsub_seq #(.WIDTH(64))  u_dut64  (.clk(clk), .rst_n(rst_n), .bus(if64.slave));
  dsp_addsub_seq #(.WIDTH(128)) u_dut128 (.clk(clk), .rst_n(rst_n), .bus(if128.slave));

  logic         m_in_ready;
  logic         m_out_valid;
  logic [127:0] m_result;
  logic         m_carry_out;
  logic         m_overflow;
  logic         m_zero;

  always_comb begin
    m_in_ready  = sel ? if128.in_ready  : if64.in_ready;
    m_out_valid = sel ? if128.out_valid : if64.out_valid;
    m_result    = sel ? if128.result    : 128'(if64.result);
    m_carry_out = sel ? if128.carry_out : if64.carry_out;
    m_overflow  = sel ? if128.overflow  : if64.overflow;
    m_zero      = sel ? if128.zero      : if64.zero;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic mod 2^w; signed overflow by range check.
  function automatic void model(input int w, input logic op, input logic [127:0] ai,
                                input logic [127:0] bi, output logic [127:0] res,
                                output logic co, output logic ov, output logic z);
    logic [129:0]        mask;
    logic [129:0]        ua;
    logic [129:0]        ub;
    logic [129:0]        full;
    logic signed [129:0] sa;
    logic signed [129:0] sb;
    logic signed [129:0] sr;
    logic signed [129:0] smax;
    logic signed [129:0] smin;
    mask = (130'd1 << w) - 130'd1;
    ua   = 130'(ai) & mask;
    ub   = 130'(bi) & mask;
    full = op ? (ua - ub) : (ua + ub);
    res  = 128'(full & mask);
    co   = op ? (ua >= ub) : full[w];
    z    = (res == 128'd0);
    sa   = $signed(ua[w-1] ? (ua | ~mask) : ua);
    sb   = $signed(ub[w-1] ? (ub | ~mask) : ub);
    sr   = op ? (sa - sb) : (sa + sb);
    smax = $signed(mask >> 1);
    smin = -smax - 130'sd1;
    ov   = (sr > smax) || (sr < smin);
  endfunction

  function automatic logic [127:0] rnd_operand();
    logic [127:0] v;
    case ($urandom_range(0, 4))
      0: v = 128'd0;
      1: v = {128{1'b1}};
      2: v = 128'd1 << ($urandom_range(0, 1) ? 127 : 63);
      3: v = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 100);
      default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic scramble_inputs();
    in_valid = 1'($urandom_range(0, 1));
    a        = {$urandom(), $urandom(), $urandom(), $urandom()};
    b        = {$urandom(), $urandom(), $urandom(), $urandom()};
    op_sub   = 1'($urandom_range(0, 1));
  endtask

  // One full transaction on the selected instance; hold = DONE cycles with out_ready low.
  task automatic run_op(input string tag, input logic op, input logic [127:0] ai,
                        input logic [127:0] bi, input int hold);
    int           w;
    int           n;
    logic [127:0] e_res;
    logic         e_co;
    logic         e_ov;
    logic         e_z;
    logic [127:0] snap;
    w = sel ? 128 : 64;
    model(w, op, ai, bi, e_res, e_co, e_ov, e_z);

    n = 0;
    while (!m_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 128'(m_in_ready), 128'd1);

    in_valid  = 1'b1;
    op_sub    = op;
    a         = ai;
    b         = bi;
    out_ready = 1'($urandom_range(0, 1));  // early out_ready must have no effect
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();

    n = 0;
    while (!m_out_valid && n < 20) begin
      check({tag, "_busy_ready"}, 128'(m_in_ready), 128'd0);
      @(negedge clk);
      n++;
      scramble_inputs();
    end
    out_ready = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'(w / 32));
    check({tag, "_result"},  m_result, e_res);
    check({tag, "_carry"},   128'(m_carry_out), 128'(e_co));
    check({tag, "_ovf"},     128'(m_overflow), 128'(e_ov));
    check({tag, "_zero"},    128'(m_zero), 128'(e_z));
    snap = {m_result[124:0], m_carry_out, m_overflow, m_zero};

    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(negedge clk);
      check({tag, "_hold_valid"}, 128'(m_out_valid), 128'd1);
      check({tag, "_hold_ready"}, 128'(m_in_ready), 128'd0);
      check({tag, "_hold_out"}, {m_result[124:0], m_carry_out, m_overflow, m_zero}, snap);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 128'(m_out_valid), 128'd0);
    check({tag, "_rise_ready"}, 128'(m_in_ready), 128'd1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  128'(if64.in_ready), 128'd0);
    check("rst_out_valid", 128'(if64.out_valid), 128'd0);
    check("rst_result",    128'(if64.result), 128'd0);
    check("rst_flags",     {125'd0, if128.carry_out, if128.overflow, if128.zero}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 128'(if64.in_ready), 128'd1);

    // Directed 64-bit cases.
    run_op("add_limb_carry", 1'b0, 128'h0000_0000_FFFF_FFFF, 128'd1, 0);
    check("d1_result", m_result, 128'h0000_0001_0000_0000);
    run_op("sub_borrow",     1'b1, 128'd0, 128'd1, 0);
    check("d2_result", m_result, 128'hFFFF_FFFF_FFFF_FFFF);
    check("d2_carry",  128'(m_carry_out), 128'd0);
    run_op("add_ovf",        1'b0, 128'h7FFF_FFFF_FFFF_FFFF, 128'd1, 0);
    check("d3_ovf",    128'(m_overflow), 128'd1);
    run_op("sub_ovf_bp",     1'b1, 128'h8000_0000_0000_0000, 128'd1, 5);
    check("d4_result", m_result, 128'h7FFF_FFFF_FFFF_FFFF);
    check("d4_ovf",    128'(m_overflow), 128'd1);
    run_op("back_to_back",   1'b0, 128'h1234_5678_9ABC_DEF0, 128'h1111_1111_1111_1111, 0);

    // Directed 128-bit X - X.
    sel = 1'b1;
    @(negedge clk);
    run_op("sub_self_128", 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
           128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
    check("d6_zero",  128'(m_zero), 128'd1);
    check("d6_carry", 128'(m_carry_out), 128'd1);

    // Asynchronous reset in the middle of CALC.
    in_valid = 1'b1;
    op_sub   = 1'b0;
    a        = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    b        = 128'h0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid",  128'(m_out_valid), 128'd0);
    check("mid_rst_ready",  128'(m_in_ready), 128'd0);
    check("mid_rst_result", m_result, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 128'(m_out_valid), 128'd0);
    end
    run_op("after_rst", 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 0);

    // Randomized operations on both widths.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      run_op(sel ? "rnd128" : "rnd64", 1'($urandom_range(0, 1)), rnd_operand(),
             rnd_operand(), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_addsub_seq.md
# dsp_addsub_seq

Parametrised multi-limb integer add/subtract unit built on one iCE40 SB_MAC16 in 32-bit adder mode. Operands of WIDTH bits are processed one 32-bit limb per cycle, least significant first, with the carry held in a register between limbs. A valid/ready handshake on each side lets the processor core or a coprocessor sequencer issue wide arithmetic such as 64/128-bit counters or bignum steps without spending fabric LUTs on a wide carry chain.

## Interface
Parameters:
- WIDTH, 64, operand/result width; multiple of 32, minimum 32
- NLIMBS, WIDTH/32, derived limb count; not overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- op_sub  in  1  0 = a+b, 1 = a-b; sampled on accept
- a  in  WIDTH  operand A; sampled on accept
- b  in  WIDTH  operand B; sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  sum/difference modulo 2^WIDTH
- carry_out  out  1  carry from MSB; for subtract, 1 = no borrow
- overflow  out  1  two's-complement signed overflow
- zero  out  1  result == 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept on an edge where in_valid&&in_ready. Latch a, b, op_sub. Set limb index to 0 and carry to op_sub. Go to CALC.
- CALC: in_ready=0. Each edge computes limb i:
  - r[i] = a[i] + (op_sub ? ~b[i] : b[i]) + carry
  - Write r[i] into the result register at limb i.
  - carry <= carry out of the limb; i <= i+1.
  - After limb NLIMBS-1, go to DONE.
- Limb adder: SB_MAC16 with all input/output registers bypassed, ADDSUBTOP/ADDSUBBOT=0, BOTADDSUB_CARRYSELECT=3 (CI from the carry register), TOPADDSUB_CARRYSELECT=2 (internal cascade). CO gives the limb carry. B inversion is done in fabric.
- DONE:
  - out_valid=1. result, carry_out, overflow and zero are all registered and held stable.
  - carry_out = final carry.
  - overflow = (sa==sb') && (sr!=sa), where sa, sb' and sr are the MSBs of A, effective B and the result.
  - zero = all result bits 0. It is computed incrementally (AND of per-limb zero) so it is valid together with out_valid.
  - On an edge with out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. In-flight requests are not queued.
- Inputs a, b and op_sub may change freely after the accept edge.

## Timing
- Reset (rst_n low, async): state=IDLE, out_valid=0, result=0, carry_out=0, overflow=0, zero=0, limb index=0, carry=0. in_ready=0 while rst_n low, 1 from the first cycle after release.
- Reset mid-CALC or mid-DONE aborts the operation. No out_valid is produced for it.
- Latency: out_valid rises NLIMBS edges after the accept edge (WIDTH=64: 2 edges).
- out_valid falls on the edge where out_valid&&out_ready. in_ready rises in the same cycle, so a new accept is possible on the next edge.
- Minimum issue interval: NLIMBS+2 cycles.
- out_ready held low: DONE persists indefinitely and all outputs are constant.
- out_ready high before DONE has no effect.
- NLIMBS=1: CALC lasts one edge. Behaviour is identical to a single 32-bit add/sub with flags.

## Test plan
- WIDTH=64, add 0x00000000_FFFFFFFF + 0x1 -> result 0x00000001_00000000, carry_out=0, overflow=0, zero=0; out_valid exactly 2 edges after accept; in_ready=0 during CALC/DONE.
- WIDTH=64, sub 0x0 - 0x1 -> result 0xFFFFFFFF_FFFFFFFF, carry_out=0 (borrow), overflow=0, zero=0.
- WIDTH=64, add 0x7FFFFFFF_FFFFFFFF + 0x1 -> result 0x80000000_00000000, overflow=1, carry_out=0. Also sub 0x80000000_00000000 - 0x1 -> 0x7FFFFFFF_FFFFFFFF, overflow=1.
- WIDTH=128, sub X - X with X=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> result 0, zero=1, carry_out=1; out_valid 4 edges after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid, a and b -> outputs unchanged, no second accept. Then out_ready=1 for one edge -> out_valid=0 and in_ready=1 next cycle; back-to-back request accepted on the following edge.
- Assert rst_n=0 asynchronously mid-CALC (between clock edges) -> outputs clear immediately, no out_valid. A subsequent request completes with correct values.
